// File: rtl/ame_pkg.sv
// Shared types and constants for the affine-motion-estimation equation builder.
//   AME_PARAM_NUM : length of the C vector (6 unknowns, 4-param uses C0..C3)
//   AME_TERM_BITS : signed width of one C-vector element
//   ame_matrix_t  : 6x7 A|B matrix in the layout the solver consumes
//   ame_tri_idx() : flat index of the upper-triangle entry (i,j) of the 6x6 A
package ame_pkg;

    localparam int unsigned AME_PARAM_NUM = 6;
    localparam int unsigned AME_TERM_BITS = 25;
    localparam int unsigned AME_DATA_BITS = 64;
    localparam int unsigned AME_TRI_NUM   = AME_PARAM_NUM * (AME_PARAM_NUM + 1) / 2;

    typedef logic signed [5:0][6:0][AME_DATA_BITS-1:0] ame_matrix_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } ame_build_state_t;

    // Row-major packing of the upper triangle; arguments may come in either order.
    function automatic int ame_tri_idx(int a, int b);
        int i;
        int j;
        i = (a < b) ? a : b;
        j = (a < b) ? b : a;
        return (i * (2 * AME_PARAM_NUM - i - 1)) / 2 + j;
    endfunction

endpackage

// File: rtl/ame_term_gen.sv
// Stage 1: per-pixel C-vector generator, registered.
//   clk_i/rst_i     : clock, async active-high reset
//   clear_i         : drops the in-flight valid (block restart)
//   valid_i         : accepted pixel beat
//   param6_i        : 1 = 6-parameter model, 0 = 4-parameter model
//   x_i/y_i         : raster position of the beat inside the block
//   gx_i/gy_i/diff_i: signed gradients and residual
//   valid_o/c_o     : registered C vector, diff_o the matching residual
module ame_term_gen
    import ame_pkg::*;
#(
    parameter int unsigned GRAD_BITS = 16,
    parameter int unsigned POS_BITS  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            valid_i,
    input  logic                            param6_i,
    input  logic [POS_BITS-1:0]             x_i,
    input  logic [POS_BITS-1:0]             y_i,
    input  logic signed [GRAD_BITS-1:0]     gx_i,
    input  logic signed [GRAD_BITS-1:0]     gy_i,
    input  logic signed [GRAD_BITS-1:0]     diff_i,
    output logic                            valid_o,
    output logic signed [AME_TERM_BITS-1:0] c_o [AME_PARAM_NUM],
    output logic signed [GRAD_BITS-1:0]     diff_o
);

    logic [POS_BITS-1:0] cx_u, cy_u;
    logic signed [AME_TERM_BITS-1:0] gx, gy, cx, cy;
    logic signed [AME_TERM_BITS-1:0] cxgx, cxgy, cygx, cygy;
    logic signed [AME_TERM_BITS-1:0] c_d [AME_PARAM_NUM];
    logic signed [AME_TERM_BITS-1:0] c_q [AME_PARAM_NUM];
    logic signed [GRAD_BITS-1:0]     diff_q;
    logic                            valid_q;

    // Centre of the 4x4 subblock: the low two bits always become 2'b10.
    assign cx_u = (x_i & ~POS_BITS'(3)) | POS_BITS'(2);
    assign cy_u = (y_i & ~POS_BITS'(3)) | POS_BITS'(2);
    assign cx   = AME_TERM_BITS'(cx_u);
    assign cy   = AME_TERM_BITS'(cy_u);
    assign gx   = AME_TERM_BITS'(gx_i);
    assign gy   = AME_TERM_BITS'(gy_i);

    assign cxgx = cx * gx;
    assign cxgy = cx * gy;
    assign cygx = cy * gx;
    assign cygy = cy * gy;

    always_comb begin
        c_d[0] = gx;
        c_d[2] = gy;
        if (param6_i) begin
            c_d[1] = cxgx;
            c_d[3] = cxgy;
            c_d[4] = cygx;
            c_d[5] = cygy;
        end else begin
            c_d[1] = cxgx + cygy;
            c_d[3] = cygx - cxgy;
            c_d[4] = '0;
            c_d[5] = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            diff_q  <= '0;
            for (int k = 0; k < AME_PARAM_NUM; k++) c_q[k] <= '0;
        end else begin
            valid_q <= valid_i & ~clear_i;
            if (valid_i) begin
                diff_q <= diff_i;
                for (int k = 0; k < AME_PARAM_NUM; k++) c_q[k] <= c_d[k];
            end
        end
    end

    assign valid_o = valid_q;
    assign c_o     = c_q;
    assign diff_o  = diff_q;

endmodule

// File: rtl/ame_equation_builder.sv
// Accumulates the affine-ME normal equations (A, B) over one block.
//   clk_i/rst_i        : clock, async active-high reset
//   comp_init_i        : start pulse, samples affine_param6_i, blk_w_i, blk_h_i, comp_data_index_i
//   pix_valid_i/ready_o: pixel beat handshake, pix_gx_i/pix_gy_i/pix_diff_i the beat payload
//   comp_done_o        : one-cycle pulse when comp_data_o/comp_data_index_o are refreshed
//   comp_data_o        : row r, cols 0..5 = A, col 6 = B, term k at row/col 5-k
module ame_equation_builder
    import ame_pkg::*;
#(
    parameter int unsigned COMP_DATA_BITS = 64,
    parameter int unsigned GRAD_BITS      = 16,
    parameter int unsigned BLK_DIM_BITS   = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    comp_init_i,
    input  logic                                    affine_param6_i,
    input  logic [BLK_DIM_BITS-1:0]                 blk_w_i,
    input  logic [BLK_DIM_BITS-1:0]                 blk_h_i,
    input  logic [7:0]                              comp_data_index_i,
    input  logic                                    pix_valid_i,
    output logic                                    pix_ready_o,
    input  logic signed [GRAD_BITS-1:0]             pix_gx_i,
    input  logic signed [GRAD_BITS-1:0]             pix_gy_i,
    input  logic signed [GRAD_BITS-1:0]             pix_diff_i,
    output logic                                    comp_done_o,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0]     comp_data_o,
    output logic [7:0]                              comp_data_index_o
);

    ame_build_state_t state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic publish, done_q;

    logic                    p6_q;
    logic [BLK_DIM_BITS-1:0] blk_w_q, blk_h_q, x_q, y_q;
    logic [7:0]              tag_q, tag_out_q;
    logic                    accept, x_last, y_last;

    logic                             s1_valid;
    logic signed [AME_TERM_BITS-1:0]  s1_c [AME_PARAM_NUM];
    logic signed [GRAD_BITS-1:0]      s1_diff;

    logic                             s2_valid_q;
    logic signed [COMP_DATA_BITS-1:0] a_prod_q [AME_TRI_NUM];
    logic signed [COMP_DATA_BITS-1:0] b_prod_q [AME_PARAM_NUM];
    logic signed [COMP_DATA_BITS-1:0] a_acc_q  [AME_TRI_NUM];
    logic signed [COMP_DATA_BITS-1:0] b_acc_q  [AME_PARAM_NUM];

    logic [5:0][6:0][COMP_DATA_BITS-1:0] matrix_d, matrix_q;

    assign pix_ready_o = (state_q == StAccum) && !comp_init_i;
    assign accept      = pix_valid_i && pix_ready_o;
    assign x_last      = (x_q == blk_w_q - BLK_DIM_BITS'(1));
    assign y_last      = (y_q == blk_h_q - BLK_DIM_BITS'(1));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        publish = 1'b0;
        unique case (state_q)
            StAccum: begin
                if (accept && x_last && y_last) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            // Three drain cycles cover the stage-1/2/3 pipeline behind the last beat.
            StDrain: begin
                if (drain_q == 2'd2) begin
                    state_d = StDone;
                    publish = 1'b1;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: ;
        endcase
        if (comp_init_i) begin
            state_d = StAccum;
            publish = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            drain_q <= '0;
            done_q  <= 1'b0;
            p6_q    <= 1'b0;
            blk_w_q <= '0;
            blk_h_q <= '0;
            tag_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            done_q  <= publish;
            if (comp_init_i) begin
                p6_q    <= affine_param6_i;
                blk_w_q <= blk_w_i;
                blk_h_q <= blk_h_i;
                tag_q   <= comp_data_index_i;
                x_q     <= '0;
                y_q     <= '0;
            end else if (accept) begin
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_q + BLK_DIM_BITS'(1);
                end else begin
                    x_q <= x_q + BLK_DIM_BITS'(1);
                end
            end
        end
    end

    ame_term_gen #(
        .GRAD_BITS (GRAD_BITS),
        .POS_BITS  (BLK_DIM_BITS)
    ) u_term_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (comp_init_i),
        .valid_i  (accept),
        .param6_i (p6_q),
        .x_i      (x_q),
        .y_i      (y_q),
        .gx_i     (pix_gx_i),
        .gy_i     (pix_gy_i),
        .diff_i   (pix_diff_i),
        .valid_o  (s1_valid),
        .c_o      (s1_c),
        .diff_o   (s1_diff)
    );

    // Stage 2 products and stage 3 accumulation; init drops in-flight data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            for (int k = 0; k < AME_TRI_NUM; k++) begin
                a_prod_q[k] <= '0;
                a_acc_q[k]  <= '0;
            end
            for (int k = 0; k < AME_PARAM_NUM; k++) begin
                b_prod_q[k] <= '0;
                b_acc_q[k]  <= '0;
            end
        end else begin
            s2_valid_q <= s1_valid & ~comp_init_i;
            for (int i = 0; i < AME_PARAM_NUM; i++) begin
                for (int j = i; j < AME_PARAM_NUM; j++) begin
                    a_prod_q[ame_tri_idx(i, j)] <=
                        COMP_DATA_BITS'(s1_c[i]) * COMP_DATA_BITS'(s1_c[j]);
                end
                b_prod_q[i] <= COMP_DATA_BITS'(s1_c[i]) * COMP_DATA_BITS'(s1_diff);
            end
            if (comp_init_i) begin
                for (int k = 0; k < AME_TRI_NUM; k++) a_acc_q[k] <= '0;
                for (int k = 0; k < AME_PARAM_NUM; k++) b_acc_q[k] <= '0;
            end else if (s2_valid_q) begin
                for (int k = 0; k < AME_TRI_NUM; k++) a_acc_q[k] <= a_acc_q[k] + a_prod_q[k];
                for (int k = 0; k < AME_PARAM_NUM; k++) b_acc_q[k] <= b_acc_q[k] + b_prod_q[k];
            end
        end
    end

    always_comb begin
        matrix_d = '0;
        for (int i = 0; i < AME_PARAM_NUM; i++) begin
            for (int j = 0; j < AME_PARAM_NUM; j++) begin
                matrix_d[5-i][5-j] = a_acc_q[ame_tri_idx(i, j)];
            end
            matrix_d[5-i][6] = b_acc_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            matrix_q  <= '0;
            tag_out_q <= '0;
        end else if (publish) begin
            matrix_q  <= matrix_d;
            tag_out_q <= tag_q;
        end
    end

    assign comp_done_o       = done_q;
    assign comp_data_o       = matrix_q;
    assign comp_data_index_o = tag_out_q;

endmodule

// File: tb/tb_ame_equation_builder.sv
module tb_ame_equation_builder;
    import ame_pkg::*;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic comp_init_i = 1'b0;
    logic affine_param6_i = 1'b0;
    logic [7:0] blk_w_i = '0, blk_h_i = '0, comp_data_index_i = '0;
    logic pix_valid_i = 1'b0;
    logic pix_ready_o;
    logic signed [15:0] pix_gx_i = '0, pix_gy_i = '0, pix_diff_i = '0;
    logic comp_done_o;
    ame_matrix_t comp_data_o;
    logic [7:0] comp_data_index_o;

    always #5 clk = ~clk;

    ame_equation_builder #(
        .COMP_DATA_BITS (64),
        .GRAD_BITS      (16),
        .BLK_DIM_BITS   (8)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .comp_init_i       (comp_init_i),
        .affine_param6_i   (affine_param6_i),
        .blk_w_i           (blk_w_i),
        .blk_h_i           (blk_h_i),
        .comp_data_index_i (comp_data_index_i),
        .pix_valid_i       (pix_valid_i),
        .pix_ready_o       (pix_ready_o),
        .pix_gx_i          (pix_gx_i),
        .pix_gy_i          (pix_gy_i),
        .pix_diff_i        (pix_diff_i),
        .comp_done_o       (comp_done_o),
        .comp_data_o       (comp_data_o),
        .comp_data_index_o (comp_data_index_o)
    );

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;

    // Reference model: full symmetric A and B, plain 64-bit wrapping arithmetic.
    longint m_a [6][6];
    longint m_b [6];
    int mx, my, mw, mh;
    bit mp6;
    logic [7:0] pend_tag, exp_tag = '0;
    ame_matrix_t exp_mat = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic model_add(longint gx, longint gy, longint df);
        longint cx, cy;
        longint c [6];
        cx = longint'((mx / 4) * 4 + 2);
        cy = longint'((my / 4) * 4 + 2);
        if (mp6) c = '{gx, cx * gx, gy, cx * gy, cy * gx, cy * gy};
        else     c = '{gx, cx * gx + cy * gy, gy, cy * gx - cx * gy, 0, 0};
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) m_a[i][j] += c[i] * c[j];
            m_b[i] += c[i] * df;
        end
        mx++;
        if (mx == mw) begin
            mx = 0;
            my++;
        end
    endtask

    task automatic model_finalize();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) exp_mat[r][c] = m_a[5-r][5-c];
            exp_mat[r][6] = m_b[5-r];
        end
        exp_tag = pend_tag;
    endtask

    // Compare process: every done pulse must present the model's matrix and tag.
    always @(negedge clk) begin
        if (comp_done_o === 1'b1) begin
            done_cnt++;
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 7; c++)
                    check($sformatf("mat[%0d][%0d]", r, c), comp_data_o[r][c], exp_mat[r][c]);
            check("tag", 64'(comp_data_index_o), 64'(exp_tag));
        end
    end

    // Called at posedge+1; leaves at posedge+1 with init deasserted and config scrambled.
    task automatic start_block(int w, int h, bit p6, logic [7:0] tag);
        comp_init_i = 1'b1;
        blk_w_i = 8'(w);
        blk_h_i = 8'(h);
        affine_param6_i = p6;
        comp_data_index_i = tag;
        pix_valid_i = 1'b1;
        @(negedge clk);
        check("ready low in init cycle", 64'(pix_ready_o), 64'(0));
        @(posedge clk);
        #1;
        comp_init_i = 1'b0;
        pix_valid_i = 1'b0;
        blk_w_i = 8'hff;
        blk_h_i = 8'hff;
        affine_param6_i = ~p6;
        comp_data_index_i = 8'hee;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) m_a[i][j] = 0;
            m_b[i] = 0;
        end
        mx = 0; my = 0; mw = w; mh = h; mp6 = p6;
        pend_tag = tag;
    endtask

    // mode 0: constant payload; mode 1: random payload. Bubbles carry junk data.
    task automatic feed(int n, bit gaps, int mode,
                        logic signed [15:0] kgx, logic signed [15:0] kgy, logic signed [15:0] kdf);
        int sent, cyc;
        sent = 0;
        cyc = 0;
        while (sent < n && cyc < 40 * n + 100) begin
            pix_valid_i = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            if (mode == 0 && pix_valid_i) begin
                pix_gx_i = kgx; pix_gy_i = kgy; pix_diff_i = kdf;
            end else begin
                pix_gx_i = 16'($urandom); pix_gy_i = 16'($urandom); pix_diff_i = 16'($urandom);
            end
            @(negedge clk);
            if (pix_valid_i && pix_ready_o) begin
                model_add(pix_gx_i, pix_gy_i, pix_diff_i);
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        pix_valid_i = 1'b0;
        check("beats accepted", 64'(sent), 64'(n));
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (comp_done_o === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL done timeout: got no pulse, expected one within 20 cycles");
        end
    endtask

    initial begin
        int lat, d0;
        @(negedge clk);
        check("reset ready", 64'(pix_ready_o), 64'(0));
        check("reset done", 64'(comp_done_o), 64'(0));
        check("reset data zero", 64'(comp_data_o == '0), 64'(1));
        check("reset tag", 64'(comp_data_index_o), 64'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // 1: 4x4, 4-param, gx=1 gy=0 diff=1
        d0 = done_cnt;
        start_block(4, 4, 1'b0, 8'd1);
        feed(16, 1'b0, 0, 16'sd1, 16'sd0, 16'sd1);
        model_finalize();
        wait_done(lat);
        check("t1 latency", 64'(lat), 64'(4));
        check("t1 done count", 64'(done_cnt), 64'(d0 + 1));
        check("t1 [5][5]", comp_data_o[5][5], 64'd16);
        check("t1 [5][4]", comp_data_o[5][4], 64'd32);
        check("t1 [4][4]", comp_data_o[4][4], 64'd64);
        check("t1 [2][4]", comp_data_o[2][4], 64'd64);
        check("t1 [2][2]", comp_data_o[2][2], 64'd64);
        check("t1 [2][6]", comp_data_o[2][6], 64'd32);
        check("t1 [3][3]", comp_data_o[3][3], 64'd0);
        check("t1 [1][1]", comp_data_o[1][1], 64'd0);

        // 2: 8x8, 6-param, gx=0 gy=2 diff=-1
        start_block(8, 8, 1'b1, 8'd3);
        feed(64, 1'b0, 0, 16'sd0, 16'sd2, -16'sd1);
        model_finalize();
        wait_done(lat);
        check("t2 [3][3]", comp_data_o[3][3], 64'd256);
        check("t2 [3][6]", comp_data_o[3][6], -64'sd128);
        check("t2 [2][2]", comp_data_o[2][2], 64'd5120);
        check("t2 [5][5]", comp_data_o[5][5], 64'd0);
        check("t2 [4][6]", comp_data_o[4][6], 64'd0);

        // 3: test 1 with random bubbles
        d0 = done_cnt;
        start_block(4, 4, 1'b0, 8'd4);
        feed(16, 1'b1, 0, 16'sd1, 16'sd0, 16'sd1);
        model_finalize();
        wait_done(lat);
        repeat (10) @(posedge clk);
        #1;
        check("t3 done unique", 64'(done_cnt), 64'(d0 + 1));
        check("t3 [4][4]", comp_data_o[4][4], 64'd64);
        check("t3 [5][6]", comp_data_o[5][6], 64'd16);

        // 4: restart after 5 beats
        d0 = done_cnt;
        start_block(4, 4, 1'b0, 8'd1);
        feed(5, 1'b0, 0, 16'sd7, 16'sd3, 16'sd5);
        start_block(4, 4, 1'b0, 8'd2);
        feed(16, 1'b0, 0, 16'sd1, 16'sd0, 16'sd1);
        model_finalize();
        wait_done(lat);
        check("t4 done count", 64'(done_cnt), 64'(d0 + 1));
        check("t4 tag", 64'(comp_data_index_o), 64'(2));
        check("t4 [5][5]", comp_data_o[5][5], 64'd16);
        check("t4 [2][2]", comp_data_o[2][2], 64'd64);

        // 5: reset during drain
        d0 = done_cnt;
        start_block(4, 4, 1'b0, 8'd5);
        feed(16, 1'b0, 0, 16'sd3, 16'sd1, 16'sd2);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t5 no done", 64'(done_cnt), 64'(d0));
        check("t5 data zero", 64'(comp_data_o == '0), 64'(1));
        check("t5 ready low", 64'(pix_ready_o), 64'(0));
        @(posedge clk);
        #1;

        // 6: 128x128, 6-param, all inputs at the negative extreme
        start_block(128, 128, 1'b1, 8'd6);
        check("t6 data zero after init", 64'(comp_data_o == '0), 64'(1));
        feed(16384, 1'b0, 0, -16'sd32768, -16'sd32768, -16'sd32768);
        model_finalize();
        wait_done(lat);
        check("t6 latency", 64'(lat), 64'(4));
        check("t6 [5][5]", comp_data_o[5][5], 64'd1 << 44);
        check("t6 [5][6]", comp_data_o[5][6], 64'd1 << 44);

        // 7: random 4-param block, restart coinciding with its done pulse, random 6-param
        d0 = done_cnt;
        start_block(8, 4, 1'b0, 8'd7);
        feed(32, 1'b1, 1, 16'sd0, 16'sd0, 16'sd0);
        model_finalize();
        repeat (3) @(posedge clk);
        #1;
        start_block(12, 8, 1'b1, 8'd8);
        check("t7 pulse with init", 64'(done_cnt), 64'(d0 + 1));
        feed(96, 1'b0, 1, 16'sd0, 16'sd0, 16'sd0);
        model_finalize();
        wait_done(lat);
        check("t7 second done", 64'(done_cnt), 64'(d0 + 2));
        check("t7 tag", 64'(comp_data_index_o), 64'(8));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
